// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the memory port arbiter.
// The watchdog default below only matters when MEM_ARB_TIMEOUT_EN is defined.
package mem_arb_pkg;

    localparam int ADDR_W_DEF      = 32;
    localparam int DATA_W_DEF      = 32;
    localparam int TIMEOUT_CYC_DEF = 255;

    // Wide enough for any sensible DATA_W/8; the top slices the bits it needs.
    localparam logic [127:0] FETCH_BE = '1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_D  = 2'd2
    } arb_state_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundles the fetch, data and memory-side handshakes of the arbiter.
// slave is the arbiter's view; master is the core plus memory model.
interface mem_port_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    localparam int BE_W = DATA_W / 8;

    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;
    logic              if_err;

    logic              d_req;
    logic              d_we;
    logic [BE_W-1:0]   d_be;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;
    logic              d_err;

    logic              m_req;
    logic              m_we;
    logic [BE_W-1:0]   m_be;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic              m_ack;
    logic [DATA_W-1:0] m_rdata;

    modport slave (
        input  if_req, if_addr,
        output if_gnt, if_rvalid, if_rdata, if_err,
        input  d_req, d_we, d_be, d_addr, d_wdata,
        output d_gnt, d_rvalid, d_rdata, d_err,
        output m_req, m_we, m_be, m_addr, m_wdata,
        input  m_ack, m_rdata
    );

    modport master (
        output if_req, if_addr,
        input  if_gnt, if_rvalid, if_rdata, if_err,
        output d_req, d_we, d_be, d_addr, d_wdata,
        input  d_gnt, d_rvalid, d_rdata, d_err,
        input  m_req, m_we, m_be, m_addr, m_wdata,
        output m_ack, m_rdata
    );

endinterface

// File: rtl/mem_arb_watchdog.sv
// Busy-cycle watchdog: counts cycles spent waiting for m_ack and flags
// expiry on the TIMEOUT_CYC-th busy cycle. Only used with MEM_ARB_TIMEOUT_EN.
module mem_arb_watchdog
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic busy_i,
    output logic expired_o
);
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] cnt_q;

    // The count sits at TIMEOUT_CYC-1 during the last allowed busy cycle.
    assign expired_o = busy_i && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

    // Restart on every capture, advance while a transaction is outstanding.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (clear_i) begin
            cnt_q <= '0;
        end else if (busy_i && !expired_o) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and load/store.
// One transaction outstanding; alternates when both sides are pending.
// Optional watchdog abort: define MEM_ARB_TIMEOUT_EN.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic               clk,
    input  logic               rst,
    mem_port_arbiter_if.slave  bus
);
    localparam int BE_W = DATA_W / 8;

    arb_state_e        state_q, state_d;
    logic              last_d_q, last_d_d;
    logic              m_req_q, m_req_d;
    logic              m_we_q, m_we_d;
    logic [BE_W-1:0]   m_be_q, m_be_d;
    logic [ADDR_W-1:0] m_addr_q, m_addr_d;
    logic [DATA_W-1:0] m_wdata_q, m_wdata_d;
    logic              if_gnt_q, if_gnt_d;
    logic              d_gnt_q, d_gnt_d;
    logic              if_rvalid_q, if_rvalid_d;
    logic              d_rvalid_q, d_rvalid_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              if_err_q, if_err_d;
    logic              d_err_q, d_err_d;

    logic busy;
    logic done;
    logic capture;
    logic grant_d;
    logic grant_if;
    logic tmo;

    assign busy     = (state_q != IDLE);
    assign done     = busy && (bus.m_ack || tmo);
    assign capture  = !busy || done;
    assign grant_d  = bus.d_req && (!bus.if_req || !last_d_q);
    assign grant_if = bus.if_req && !grant_d;

`ifdef MEM_ARB_TIMEOUT_EN
    mem_arb_watchdog #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_watchdog (
        .clk       (clk),
        .rst       (rst),
        .clear_i   (capture),
        .busy_i    (busy),
        .expired_o (tmo)
    );
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYC;
    assign tmo = 1'b0;
`endif

    // Completion of the current owner, then arbitration at each capture point.
    always_comb begin
        state_d     = state_q;
        last_d_d    = last_d_q;
        m_req_d     = m_req_q;
        m_we_d      = m_we_q;
        m_be_d      = m_be_q;
        m_addr_d    = m_addr_q;
        m_wdata_d   = m_wdata_q;
        if_gnt_d    = 1'b0;
        d_gnt_d     = 1'b0;
        if_rvalid_d = 1'b0;
        d_rvalid_d  = 1'b0;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        if_err_d    = 1'b0;
        d_err_d     = 1'b0;

        if (done) begin
            if (state_q == BUSY_IF) begin
                if_rvalid_d = 1'b1;
                if_err_d    = !bus.m_ack;
                if_rdata_d  = bus.m_ack ? bus.m_rdata : '0;
            end else begin
                d_rvalid_d = 1'b1;
                d_err_d    = !bus.m_ack;
                d_rdata_d  = (bus.m_ack && !m_we_q) ? bus.m_rdata : '0;
            end
        end

        if (capture) begin
            if (grant_d) begin
                state_d   = BUSY_D;
                last_d_d  = 1'b1;
                d_gnt_d   = 1'b1;
                m_req_d   = 1'b1;
                m_we_d    = bus.d_we;
                m_be_d    = bus.d_be;
                m_addr_d  = bus.d_addr;
                m_wdata_d = bus.d_wdata;
            end else if (grant_if) begin
                state_d   = BUSY_IF;
                last_d_d  = 1'b0;
                if_gnt_d  = 1'b1;
                m_req_d   = 1'b1;
                m_we_d    = 1'b0;
                m_be_d    = FETCH_BE[BE_W-1:0];
                m_addr_d  = bus.if_addr;
                m_wdata_d = '0;
            end else begin
                state_d = IDLE;
                m_req_d = 1'b0;
                m_we_d  = 1'b0;
            end
        end
    end

    // All outputs come straight from flops; reset abandons any transaction.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            last_d_q    <= 1'b0;
            m_req_q     <= 1'b0;
            m_we_q      <= 1'b0;
            m_be_q      <= '0;
            m_addr_q    <= '0;
            m_wdata_q   <= '0;
            if_gnt_q    <= 1'b0;
            d_gnt_q     <= 1'b0;
            if_rvalid_q <= 1'b0;
            d_rvalid_q  <= 1'b0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            if_err_q    <= 1'b0;
            d_err_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_d_q    <= last_d_d;
            m_req_q     <= m_req_d;
            m_we_q      <= m_we_d;
            m_be_q      <= m_be_d;
            m_addr_q    <= m_addr_d;
            m_wdata_q   <= m_wdata_d;
            if_gnt_q    <= if_gnt_d;
            d_gnt_q     <= d_gnt_d;
            if_rvalid_q <= if_rvalid_d;
            d_rvalid_q  <= d_rvalid_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
            if_err_q    <= if_err_d;
            d_err_q     <= d_err_d;
        end
    end

    assign bus.m_req     = m_req_q;
    assign bus.m_we      = m_we_q;
    assign bus.m_be      = m_be_q;
    assign bus.m_addr    = m_addr_q;
    assign bus.m_wdata   = m_wdata_q;
    assign bus.if_gnt    = if_gnt_q;
    assign bus.d_gnt     = d_gnt_q;
    assign bus.if_rvalid = if_rvalid_q;
    assign bus.d_rvalid  = d_rvalid_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.if_err    = if_err_q;
    assign bus.d_err     = d_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: single fetch, simultaneous requests,
// sustained alternation, delayed store ack, reset mid-transaction and,
// when MEM_ARB_TIMEOUT_EN is defined, a watchdog abort.
module tb_mem_port_arbiter;

    localparam int TB_TIMEOUT = 4;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    mem_port_arbiter_if bus ();

    mem_port_arbiter #(
        .TIMEOUT_CYC (TB_TIMEOUT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case the directed sequence ever stalls.
    initial begin
        #200000;
        $display("[TB] FAIL global_timeout simulation did not finish");
        $fatal(1, "[TB] stalled");
    end

    task automatic applyStimulus(input logic ifReq, input logic [31:0] ifAddr,
                                 input logic dReq, input logic dWe, input logic [3:0] dBe,
                                 input logic [31:0] dAddr, input logic [31:0] dWdata,
                                 input logic mAck, input logic [31:0] mRdata);
        bus.if_req  = ifReq;
        bus.if_addr = ifAddr;
        bus.d_req   = dReq;
        bus.d_we    = dWe;
        bus.d_be    = dBe;
        bus.d_addr  = dAddr;
        bus.d_wdata = dWdata;
        bus.m_ack   = mAck;
        bus.m_rdata = mRdata;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Moves to 1 time unit after the next rising edge.
    task automatic stepClock();
        @(posedge clk);
        #1;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst    = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #3;
        checkOutput("rst_m_req",     bus.m_req,     0);
        checkOutput("rst_m_we",      bus.m_we,      0);
        checkOutput("rst_m_be",      bus.m_be,      0);
        checkOutput("rst_m_addr",    bus.m_addr,    0);
        checkOutput("rst_gnt",       {bus.if_gnt, bus.d_gnt}, 0);
        checkOutput("rst_rvalid",    {bus.if_rvalid, bus.d_rvalid}, 0);
        checkOutput("rst_if_rdata",  bus.if_rdata,  0);
        @(posedge clk);
        #3 rst = 1'b1;

        // Single fetch with ack in the first m_req cycle.
        applyStimulus(1, 32'h10, 0, 0, 0, 0, 0, 0, 0);
        stepClock();
        checkOutput("t1_if_gnt",     bus.if_gnt,    1);
        checkOutput("t1_m_req",      bus.m_req,     1);
        checkOutput("t1_m_be",       bus.m_be,      4'hF);
        checkOutput("t1_m_we",       bus.m_we,      0);
        checkOutput("t1_m_addr",     bus.m_addr,    32'h10);
        checkOutput("t1_if_rvalid0", bus.if_rvalid, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 32'h00500093);
        stepClock();
        checkOutput("t1_if_rvalid",  bus.if_rvalid, 1);
        checkOutput("t1_if_rdata",   bus.if_rdata,  32'h00500093);
        checkOutput("t1_if_err",     bus.if_err,    0);
        checkOutput("t1_gnt_drop",   bus.if_gnt,    0);
        checkOutput("t1_m_req_drop", bus.m_req,     0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        stepClock();
        checkOutput("t1_rvalid_one", bus.if_rvalid, 0);

        // Fresh reset, then both request together: data first, fetch right after.
        rst = 1'b0;
        #2 rst = 1'b1;
        applyStimulus(1, 32'h20, 1, 0, 4'hF, 32'h40, 0, 0, 0);
        stepClock();
        checkOutput("t2_d_gnt",      bus.d_gnt,     1);
        checkOutput("t2_if_gnt0",    bus.if_gnt,    0);
        checkOutput("t2_m_addr_d",   bus.m_addr,    32'h40);
        applyStimulus(1, 32'h20, 0, 0, 0, 0, 0, 1, 32'h11111111);
        stepClock();
        checkOutput("t2_d_rvalid",   bus.d_rvalid,  1);
        checkOutput("t2_d_rdata",    bus.d_rdata,   32'h11111111);
        checkOutput("t2_if_gnt",     bus.if_gnt,    1);
        checkOutput("t2_m_req_held", bus.m_req,     1);
        checkOutput("t2_m_addr_if",  bus.m_addr,    32'h20);
        checkOutput("t2_if_rvalid0", bus.if_rvalid, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 32'h22222222);
        stepClock();
        checkOutput("t2_if_rvalid",  bus.if_rvalid, 1);
        checkOutput("t2_if_rdata",   bus.if_rdata,  32'h22222222);
        checkOutput("t2_m_req_drop", bus.m_req,     0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Both held for six grants with immediate acks: D, IF, D, IF, D, IF.
        applyStimulus(1, 32'h100, 1, 0, 4'hF, 32'h200, 0, 1, 32'h55);
        for (int k = 1; k <= 6; k++) begin
            stepClock();
            checkOutput($sformatf("t3_d_gnt_%0d", k),     bus.d_gnt,    (k % 2 == 1));
            checkOutput($sformatf("t3_if_gnt_%0d", k),    bus.if_gnt,   (k % 2 == 0));
            checkOutput($sformatf("t3_m_addr_%0d", k),    bus.m_addr,
                        (k % 2 == 1) ? 32'h200 : 32'h100);
            checkOutput($sformatf("t3_d_rvalid_%0d", k),  bus.d_rvalid, (k % 2 == 0));
            checkOutput($sformatf("t3_if_rvalid_%0d", k), bus.if_rvalid, (k % 2 == 1) && (k >= 3));
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 32'h55);
        stepClock();
        checkOutput("t3_last_if_rvalid", bus.if_rvalid, 1);
        checkOutput("t3_idle_m_req",     bus.m_req,     0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Store with ack held off for five cycles.
        applyStimulus(0, 0, 1, 1, 4'h3, 32'h80, 32'hCAFEBABE, 0, 0);
        stepClock();
        checkOutput("t4_d_gnt",      bus.d_gnt,     1);
        checkOutput("t4_m_we",       bus.m_we,      1);
        checkOutput("t4_m_be",       bus.m_be,      4'h3);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 32'hDEADBEEF);
        for (int i = 0; i < 5; i++) begin
            stepClock();
            checkOutput($sformatf("t4_m_req_%0d", i),   bus.m_req,    1);
            checkOutput($sformatf("t4_m_addr_%0d", i),  bus.m_addr,   32'h80);
            checkOutput($sformatf("t4_m_wdata_%0d", i), bus.m_wdata,  32'hCAFEBABE);
            checkOutput($sformatf("t4_m_be_%0d", i),    bus.m_be,     4'h3);
            checkOutput($sformatf("t4_gnt_%0d", i),     bus.d_gnt,    0);
            checkOutput($sformatf("t4_rvalid_%0d", i),  bus.d_rvalid, 0);
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 32'hDEADBEEF);
        stepClock();
        checkOutput("t4_d_rvalid",   bus.d_rvalid,  1);
        checkOutput("t4_d_rdata",    bus.d_rdata,   0);
        checkOutput("t4_d_err",      bus.d_err,     0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        stepClock();
        checkOutput("t4_rvalid_one", bus.d_rvalid,  0);

        // Reset asserted between edges while a load is outstanding.
        applyStimulus(0, 0, 1, 0, 4'hF, 32'h90, 0, 0, 0);
        stepClock();
        checkOutput("t5_d_gnt",      bus.d_gnt,     1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #2 rst = 1'b0;
        #1;
        checkOutput("t5_m_req_drop", bus.m_req,     0);
        checkOutput("t5_gnt_drop",   bus.d_gnt,     0);
        checkOutput("t5_rvalid",     bus.d_rvalid,  0);
        #2 rst = 1'b1;
        applyStimulus(0, 0, 1, 0, 4'hF, 32'hA0, 0, 0, 0);
        stepClock();
        checkOutput("t5_regnt",      bus.d_gnt,     1);
        checkOutput("t5_m_addr",     bus.m_addr,    32'hA0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 32'h33333333);
        stepClock();
        checkOutput("t5_d_rvalid",   bus.d_rvalid,  1);
        checkOutput("t5_d_rdata",    bus.d_rdata,   32'h33333333);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);

`ifdef MEM_ARB_TIMEOUT_EN
        // Load never acked: aborts after four busy cycles, pending fetch follows.
        applyStimulus(0, 0, 1, 0, 4'hF, 32'hB0, 0, 0, 0);
        stepClock();
        checkOutput("t6_d_gnt",      bus.d_gnt,     1);
        applyStimulus(1, 32'hC0, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 2; k <= TB_TIMEOUT; k++) begin
            stepClock();
            checkOutput($sformatf("t6_wait_rvalid_%0d", k), bus.d_rvalid, 0);
            checkOutput($sformatf("t6_wait_m_req_%0d", k),  bus.m_req,    1);
        end
        stepClock();
        checkOutput("t6_d_rvalid",   bus.d_rvalid,  1);
        checkOutput("t6_d_err",      bus.d_err,     1);
        checkOutput("t6_d_rdata",    bus.d_rdata,   0);
        checkOutput("t6_if_gnt",     bus.if_gnt,    1);
        checkOutput("t6_m_addr",     bus.m_addr,    32'hC0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 32'h44444444);
        stepClock();
        checkOutput("t6_if_rvalid",  bus.if_rvalid, 1);
        checkOutput("t6_if_err",     bus.if_err,    0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
`endif

        stepClock();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
